sitcp_tx_merger: RTL and testbench
==================================

# sitcp_tx_merger

Parametrised multi-channel transmit merger placed between user data sources and the SiTCP TCP transmit FIFO interface. It buffers NCH independent word-wide channels in per-channel FIFOs and arbitrates between them round-robin in bursts. Each selected word is serialised into bytes, MSB first, onto TCP_TX_DATA/TCP_TX_WR, with backpressure from TCP_TX_FULL. All buffered data is flushed whenever the TCP connection is not open.

## Interface
- NCH, 4: channel count, 1..16
- WBYTES, 4: bytes per channel word, 1..8
- DEPTH, 16: words per channel FIFO, power of 2, ≥4
- BURST, 8: maximum words sent per grant, ≥1
- AFULL, 12: CH_AFULL threshold in words, 1..DEPTH
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- TCP_OPEN_ACK  in  1  connection open; low flushes and blocks all channels
- TCP_TX_FULL  in  1  SiTCP almost-full; high stalls byte output
- CH_WR  in  NCH  per-channel write strobe
- CH_DATA  in  NCH*WBYTES*8  channel c word at [c*WBYTES*8 +: WBYTES*8]
- CH_OVF_CLR  in  NCH  clears matching CH_OVF bit
- CH_AFULL  out  NCH  channel FIFO count ≥ AFULL
- CH_OVF  out  NCH  sticky: a write was dropped on a full FIFO
- TCP_TX_WR  out  1  byte valid to SiTCP
- TCP_TX_DATA  out  8  byte to SiTCP
- BUSY  out  1  arbiter not in IDLE

## Operation
- Per-channel circular FIFO with rd/wr pointers and a count of width log2(DEPTH)+1.
- A write with count==DEPTH is dropped and sets CH_OVF[c]. This holds even if a pop happens in the same cycle.
- A write and a pop in the same cycle on a non-full FIFO leave count unchanged.
- CH_OVF_CLR[c] clears CH_OVF[c]. A clear and a new overflow in the same cycle: the overflow wins.
- State machine: IDLE → HDR (macro only) → SEND → IDLE.
- IDLE: search channels starting at last_grant+1 modulo NCH. The first channel with nonempty FIFO is granted and the state advances. last_grant resets to NCH-1, so channel 0 is granted first.
- SEND: a byte index counts 0..WBYTES-1 and is output as word[(WBYTES-1-idx)*8 +: 8].
- The FIFO pops on the last byte of each word, and the burst counter increments there.
- SEND → IDLE after the last byte when the burst counter reaches BURST, or when the FIFO would become empty.
- A byte advances only in cycles where TCP_TX_FULL==0. Otherwise state, index and data hold.
- TCP_OPEN_ACK low, checked synchronously and with priority over everything else:
  - all counts and pointers are cleared; any partial word is discarded;
  - state returns to IDLE and TCP_TX_WR is 0 on the next edge;
  - CH_WR is ignored and does not set CH_OVF;
  - CH_OVF and last_grant are retained.
- CH_AFULL is registered from the updated count.

## Timing
- Reset values: TCP_TX_WR=0, TCP_TX_DATA=8'h00, CH_AFULL=0, CH_OVF=0, BUSY=0, all FIFOs empty, state IDLE.
- RST assertion mid-burst forces the reset values immediately (asynchronous) and discards all data.
- TCP_TX_WR/TCP_TX_DATA are registered. A byte is issued at edge t+1 iff TCP_TX_FULL==0 during cycle t.
- Latency: CH_WR at edge t into an empty FIFO with the arbiter idle gives grant at edge t+1 and the first TCP_TX_WR at edge t+2. With the macro enabled, t+2 carries the header and t+3 carries the first data byte.
- Throughput: 1 byte/cycle within a burst. There is exactly one non-write IDLE cycle between bursts.

## Configuration
- SITCP_TX_HEADER_EN defined: each grant emits one header byte {4'hA, channel[3:0]} in HDR before the data bytes. The header obeys TCP_TX_FULL like data.
- SITCP_TX_HEADER_EN undefined: IDLE goes directly to SEND and the stream carries raw data bytes only.

## Test plan
All scenarios use default parameters, macro undefined unless stated.
- Single word 0x11223344 on ch2 → bytes 11,22,33,44 on consecutive cycles, first TCP_TX_WR 2 cycles after CH_WR. With the macro: A2,11,22,33,44.
- 10 words preloaded on each of ch0..3 → bursts ch0,1,2,3 of 32 bytes each, then ch0,1,2,3 of 8 bytes each. Total 160 bytes, in order, with one gap cycle between bursts.
- TCP_TX_FULL high for 5 cycles mid-word → TCP_TX_WR low for exactly 5 cycles, delayed by one cycle. No byte lost or duplicated.
- 17 writes to ch1 while TCP_TX_FULL is high → CH_AFULL[1] rises after the 12th write and the 17th write sets CH_OVF[1]. After release, exactly 16 words (64 bytes) are output. CH_OVF_CLR[1] then clears CH_OVF[1].
- TCP_OPEN_ACK dropped mid-burst → TCP_TX_WR 0 next edge, CH_AFULL all 0, BUSY 0. After reassertion, a new word 0xDEADBEEF outputs DE,AD,BE,EF.
- RST pulsed mid-burst → all outputs at reset values before the next edge, and no residual bytes afterwards.

Source files
------------

// File: rtl/sitcp_tx_merger.sv
// Multi-channel round-robin burst merger feeding the SiTCP TCP transmit byte stream.
// Define SITCP_TX_HEADER_EN to prefix every grant with a {4'hA, channel} header byte.
module sitcp_tx_merger #(
    parameter int NCH    = 4,
    parameter int WBYTES = 4,
    parameter int DEPTH  = 16,
    parameter int BURST  = 8,
    parameter int AFULL  = 12
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      TCP_OPEN_ACK,
    input  logic                      TCP_TX_FULL,
    input  logic [NCH-1:0]            CH_WR,
    input  logic [NCH*WBYTES*8-1:0]   CH_DATA,
    input  logic [NCH-1:0]            CH_OVF_CLR,
    output logic [NCH-1:0]            CH_AFULL,
    output logic [NCH-1:0]            CH_OVF,
    output logic                      TCP_TX_WR,
    output logic [7:0]                TCP_TX_DATA,
    output logic                      BUSY
);
    localparam int W  = WBYTES * 8;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IW = (WBYTES > 1) ? $clog2(WBYTES) : 1;
    localparam int BW = $clog2(BURST + 1);

    localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AFULL_CNT  = (AW+1)'(AFULL);
    localparam logic [AW:0]   ONE_CNT    = (AW+1)'(1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(WBYTES - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, SEND = 2'd2} state_t;

    state_t           state, state_next;
    logic [W-1:0]     mem [NCH][DEPTH];
    logic [AW-1:0]    rd_ptr [NCH];
    logic [AW-1:0]    wr_ptr [NCH];
    logic [AW:0]      count [NCH];
    logic [AW:0]      count_next [NCH];
    logic [NCH-1:0]   push, pop_ch, ovf_set;
    logic [CW-1:0]    cur_ch, last_grant, grant_ch, cand_ch;
    logic             grant_found, take_grant;
    logic [IW-1:0]    byte_idx;
    logic [BW-1:0]    burst_cnt;
    logic             issue, last_byte, pop, end_burst;
    logic [W-1:0]     cur_word, shifted;
    logic [7:0]       out_byte;

    // Writes are accepted only while the connection is open and the FIFO has room.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            push[c]       = TCP_OPEN_ACK && CH_WR[c] && (count[c] != DEPTH_CNT);
            ovf_set[c]    = TCP_OPEN_ACK && CH_WR[c] && (count[c] == DEPTH_CNT);
            pop_ch[c]     = pop && (cur_ch == CW'(c));
            count_next[c] = count[c] + (AW+1)'(push[c]) - (AW+1)'(pop_ch[c]);
            if (!TCP_OPEN_ACK) begin
                count_next[c] = '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < NCH; c++) begin
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                count[c]  <= '0;
            end
            CH_AFULL <= '0;
            CH_OVF   <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                count[c]    <= count_next[c];
                CH_AFULL[c] <= (count_next[c] >= AFULL_CNT);
                CH_OVF[c]   <= ovf_set[c] | (CH_OVF[c] & ~CH_OVF_CLR[c]);
                if (!TCP_OPEN_ACK) begin
                    rd_ptr[c] <= '0;
                    wr_ptr[c] <= '0;
                end else begin
                    if (push[c])   wr_ptr[c] <= wr_ptr[c] + 1'b1;
                    if (pop_ch[c]) rd_ptr[c] <= rd_ptr[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int c = 0; c < NCH; c++) begin
            if (push[c]) mem[c][wr_ptr[c]] <= CH_DATA[c*W +: W];
        end
    end

    // Round-robin search starts one past the previous grant.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = last_grant;
        cand_ch     = last_grant;
        for (int i = 1; i <= NCH; i++) begin
            cand_ch = CW'((int'(last_grant) + i) % NCH);
            if (!grant_found && (count[cand_ch] != '0)) begin
                grant_found = 1'b1;
                grant_ch    = cand_ch;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!TCP_OPEN_ACK) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
`ifdef SITCP_TX_HEADER_EN
                    if (grant_found) state_next = HDR;
`else
                    if (grant_found) state_next = SEND;
`endif
                end
                HDR:     if (issue) state_next = SEND;
                SEND:    if (end_burst) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // A byte is offered to SiTCP (TCP_TX_WR) only in a cycle where TCP_TX_FULL was low;
    // otherwise the arbiter holds its position and the byte is retried.
    always_comb begin
        BUSY       = (state != IDLE);
        take_grant = (state == IDLE) && TCP_OPEN_ACK && grant_found;
        issue      = TCP_OPEN_ACK && !TCP_TX_FULL && (state != IDLE);
        last_byte  = (state == SEND) && (byte_idx == IDX_LAST);
        pop        = issue && last_byte;
        end_burst  = pop && ((burst_cnt == BURST_LAST) || (count[cur_ch] == ONE_CNT));
        cur_word   = mem[cur_ch][rd_ptr[cur_ch]];
        shifted    = cur_word >> {IDX_LAST - byte_idx, 3'b000};
        out_byte   = shifted[7:0];
`ifdef SITCP_TX_HEADER_EN
        if (state == HDR) out_byte = {4'hA, 4'(cur_ch)};
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur_ch      <= '0;
            last_grant  <= CW'(NCH - 1);
            byte_idx    <= '0;
            burst_cnt   <= '0;
            TCP_TX_WR   <= 1'b0;
            TCP_TX_DATA <= 8'h00;
        end else begin
            TCP_TX_WR <= issue;
            if (issue) TCP_TX_DATA <= out_byte;
            if (!TCP_OPEN_ACK) begin
                byte_idx  <= '0;
                burst_cnt <= '0;
            end else if (take_grant) begin
                cur_ch     <= grant_ch;
                last_grant <= grant_ch;
                byte_idx   <= '0;
                burst_cnt  <= '0;
            end else if (issue && (state == SEND)) begin
                byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
                if (last_byte) burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sitcp_tx_merger.sv
// Directed bench for sitcp_tx_merger: byte scoreboard plus timing checks on the write stream.
module tb_sitcp_tx_merger;
    localparam int NCH = 4, WBYTES = 4, DEPTH = 16, BURST = 8, AFULL = 12;
`ifdef SITCP_TX_HEADER_EN
    localparam int HB = 1;
`else
    localparam int HB = 0;
`endif

    logic         clk = 1'b0;
    logic         rst, open_ack, tx_full;
    logic [3:0]   ch_wr, ovf_clr;
    logic [127:0] ch_data;
    logic [3:0]   ch_afull, ch_ovf;
    logic         tx_wr, busy;
    logic [7:0]   tx_data;

    int checks = 0, errors = 0, cyc = 0, n_bytes = 0;
    logic [7:0] exp_q[$];
    int wr_cyc_q[$];
    logic [7:0] exp_b;

    sitcp_tx_merger #(.NCH(NCH), .WBYTES(WBYTES), .DEPTH(DEPTH), .BURST(BURST), .AFULL(AFULL)) dut (
        .CLK(clk), .RST(rst), .TCP_OPEN_ACK(open_ack), .TCP_TX_FULL(tx_full),
        .CH_WR(ch_wr), .CH_DATA(ch_data), .CH_OVF_CLR(ovf_clr),
        .CH_AFULL(ch_afull), .CH_OVF(ch_ovf), .TCP_TX_WR(tx_wr), .TCP_TX_DATA(tx_data), .BUSY(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every emitted byte must match the head of the expected queue.
    always @(negedge clk) begin
        if (tx_wr === 1'b1) begin
            wr_cyc_q.push_back(cyc);
            n_bytes++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_byte observed=%02h expected=none", tx_data);
            end
            if (exp_q.size() != 0) begin
                exp_b = exp_q.pop_front();
                checks++;
                assert (tx_data === exp_b) else begin
                    errors++;
                    $error("FAIL tx_byte observed=%02h expected=%02h", tx_data, exp_b);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_hdr(input int ch);
        logic [7:0] h;
        h = {4'hA, ch[3:0]};
        if (HB == 1) exp_q.push_back(h);
    endtask

    task automatic exp_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[31-8*b -: 8]);
    endtask

    task automatic write_word(input int ch, input logic [31:0] w);
        ch_wr = '0;
        ch_wr[ch] = 1'b1;
        ch_data[ch*32 +: 32] = w;
        tick();
        ch_wr = '0;
    endtask

    task automatic wait_bytes(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && n_bytes < target; i++) begin
            @(negedge clk);
            #1;
        end
        check(tag, 64'(n_bytes >= target), 64'd1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check(tag, 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    task automatic gap_stats(output int n_gaps, output int bad_gaps, output int max_gap);
        int d;
        n_gaps = 0; bad_gaps = 0; max_gap = 0;
        for (int i = 1; i < wr_cyc_q.size(); i++) begin
            d = wr_cyc_q[i] - wr_cyc_q[i-1];
            if (d != 1) n_gaps++;
            if (d != 1 && d != 2) bad_gaps++;
            if (d > max_gap) max_gap = d;
        end
    endtask

    logic [31:0] data [4][10];
    logic [31:0] w17 [17];
    logic [31:0] w0, w1;
    int wr_edge, base, base2, n_gaps, bad_gaps, max_gap;

    initial begin
        rst = 1'b1; open_ack = 1'b1; tx_full = 1'b0;
        ch_wr = '0; ovf_clr = '0; ch_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("rst_tx_wr", 64'(tx_wr), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'h00);
        check("rst_afull", 64'(ch_afull), 64'h0);
        check("rst_ovf", 64'(ch_ovf), 64'h0);
        check("rst_busy", 64'(busy), 64'd0);

        // Ten words preloaded per channel: two round-robin passes, 8-word then 2-word bursts.
        tx_full = 1'b1;
        wr_cyc_q.delete();
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 10; k++) data[c][k] = $urandom;
        for (int k = 0; k < 10; k++) begin
            ch_wr = 4'hF;
            for (int c = 0; c < 4; c++) ch_data[c*32 +: 32] = data[c][k];
            tick();
        end
        ch_wr = '0;
        check("rr_afull_below", 64'(ch_afull), 64'h0);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) begin
                exp_hdr(c);
                for (int k = r*8; k < ((r == 0) ? 8 : 10); k++) exp_word(data[c][k]);
            end
        base = n_bytes;
        tx_full = 1'b0;
        wait_drain("rr_drain", 2000);
        check("rr_bytes", 64'(n_bytes - base), 64'(160 + 8*HB));
        gap_stats(n_gaps, bad_gaps, max_gap);
        check("rr_gap_count", 64'(n_gaps), 64'd7);
        check("rr_gap_width", 64'(bad_gaps), 64'd0);

        // Single word on ch2: latency and back-to-back bytes.
        wr_cyc_q.delete();
        exp_hdr(2);
        exp_word(32'h11223344);
        write_word(2, 32'h11223344);
        wr_edge = cyc;
        wait_drain("single_drain", 100);
        check("single_bytes", 64'(wr_cyc_q.size()), 64'(4 + HB));
        if (wr_cyc_q.size() > 0) begin
            check("single_latency", 64'(wr_cyc_q[0]), 64'(wr_edge + 2));
            check("single_span", 64'(wr_cyc_q[wr_cyc_q.size()-1] - wr_cyc_q[0]), 64'(3 + HB));
        end
        check("single_busy_idle", 64'(busy), 64'd0);

        // Five-cycle stall mid-word on ch3.
        wr_cyc_q.delete();
        w0 = $urandom; w1 = $urandom;
        exp_hdr(3); exp_word(w0); exp_word(w1);
        base = n_bytes;
        write_word(3, w0);
        write_word(3, w1);
        wait_bytes("stall_start", base + 1 + HB, 50);
        tx_full = 1'b1;
        repeat (5) @(posedge clk);
        #1 tx_full = 1'b0;
        wait_drain("stall_drain", 100);
        check("stall_bytes", 64'(n_bytes - base), 64'(8 + HB));
        gap_stats(n_gaps, bad_gaps, max_gap);
        check("stall_gap_count", 64'(n_gaps), 64'd1);
        check("stall_gap_len", 64'(max_gap), 64'd6);

        // Seventeen writes to ch1 while SiTCP is full: almost-full and overflow.
        tx_full = 1'b1;
        for (int k = 0; k < 17; k++) begin
            w17[k] = $urandom_range(32'h7FFF_FFFF, 0);
            write_word(1, w17[k]);
            if (k == 10) check("ovf_afull_11", 64'(ch_afull[1]), 64'd0);
            if (k == 11) check("ovf_afull_12", 64'(ch_afull[1]), 64'd1);
            if (k == 15) check("ovf_before_17", 64'(ch_ovf), 64'h0);
            if (k == 16) check("ovf_after_17", 64'(ch_ovf), 64'h2);
        end
        for (int r = 0; r < 2; r++) begin
            exp_hdr(1);
            for (int k = r*8; k < r*8 + 8; k++) exp_word(w17[k]);
        end
        base = n_bytes;
        tx_full = 1'b0;
        wait_drain("ovf_drain", 400);
        check("ovf_bytes", 64'(n_bytes - base), 64'(64 + 2*HB));
        check("ovf_afull_drained", 64'(ch_afull), 64'h0);
        check("ovf_sticky", 64'(ch_ovf), 64'h2);
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = '0;
        check("ovf_cleared", 64'(ch_ovf), 64'h0);

        // Connection drop mid-burst on ch0 flushes everything.
        tx_full = 1'b1;
        for (int k = 0; k < 14; k++) begin
            w17[k] = $urandom;
            write_word(0, w17[k]);
        end
        check("open_afull_before", 64'(ch_afull), 64'h1);
        exp_hdr(0);
        for (int k = 0; k < 8; k++) exp_word(w17[k]);
        exp_hdr(0);
        for (int k = 8; k < 14; k++) exp_word(w17[k]);
        base = n_bytes;
        tx_full = 1'b0;
        wait_bytes("open_mid_burst", base + 10, 100);
        tick();
        open_ack = 1'b0;
        tick();
        check("open_tx_wr", 64'(tx_wr), 64'd0);
        check("open_busy", 64'(busy), 64'd0);
        check("open_afull", 64'(ch_afull), 64'h0);
        exp_q.delete();
        base2 = n_bytes;
        write_word(2, 32'h5555_5555);
        tick();
        open_ack = 1'b1;
        repeat (8) tick();
        check("open_flushed", 64'(n_bytes - base2), 64'd0);
        check("open_no_ovf", 64'(ch_ovf), 64'h0);
        exp_hdr(0);
        exp_word(32'hDEADBEEF);
        write_word(0, 32'hDEADBEEF);
        wait_drain("open_new_word", 100);
        check("open_new_bytes", 64'(n_bytes - base2), 64'(4 + HB));

        // Asynchronous reset mid-burst.
        exp_hdr(1);
        for (int k = 0; k < 4; k++) begin
            w17[k] = $urandom;
            exp_word(w17[k]);
        end
        base = n_bytes;
        for (int k = 0; k < 4; k++) write_word(1, w17[k]);
        wait_bytes("rst_mid_burst", base + 5, 100);
        #2 rst = 1'b1;
        #1;
        check("arst_tx_wr", 64'(tx_wr), 64'd0);
        check("arst_tx_data", 64'(tx_data), 64'h00);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_afull", 64'(ch_afull), 64'h0);
        exp_q.delete();
        base2 = n_bytes;
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("arst_no_residual", 64'(n_bytes - base2), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
